// File: rtl/circuit_unit.sv
`timescale 1ns/1ps
// circuit_unit: 4-input truth-table function with a registered copy, change flag and saturating ones counter.
// Optional macro CIRCUIT_PROG_TT_EN adds a writable table register loaded through tt_we/tt_wdata.
module circuit_unit #(
   parameter logic [15:0] TT_DEFAULT = 16'hA1AD,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
`ifdef CIRCUIT_PROG_TT_EN
   input  logic             tt_we,
   input  logic [15:0]      tt_wdata,
`endif
   output logic             F,
   output logic             F_q,
   output logic             F_chg,
   output logic [CNT_W-1:0] ones_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0]  idx;
   logic [15:0] tt;

   assign idx = {a, b, c, d};

`ifdef CIRCUIT_PROG_TT_EN
   // Table register; a write becomes visible on F from the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt <= TT_DEFAULT;
      end else if (tt_we) begin
         tt <= tt_wdata;
      end
   end
`else
   assign tt = TT_DEFAULT;
`endif

   // Pure lookup: no clock dependence, X on the index may propagate.
   assign F = tt[idx];

   // Side path samples the current F, so a same-edge table write never affects the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         F_q      <= 1'b0;
         F_chg    <= 1'b0;
         ones_cnt <= '0;
      end else begin
         F_q   <= F;
         F_chg <= (F != F_q);
         if (F && (ones_cnt != CNT_MAX)) begin
            ones_cnt <= ones_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_circuit_unit.sv
`timescale 1ns/1ps
// Directed self-checking bench for circuit_unit (default table 16'hA1AD, 8-bit counter).
module tb_circuit_unit;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst_n;
   logic       a, b, c, d;
   logic       F, F_q, F_chg;
   logic [7:0] ones_cnt;
`ifdef CIRCUIT_PROG_TT_EN
   logic        tt_we;
   logic [15:0] tt_wdata;
`endif

   int vectors = 0;
   int errs    = 0;

   circuit_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
`ifdef CIRCUIT_PROG_TT_EN
      .tt_we    (tt_we),
      .tt_wdata (tt_wdata),
`endif
      .F        (F),
      .F_q      (F_q),
      .F_chg    (F_chg),
      .ones_cnt (ones_cnt)
   );

   always #5 if (clk_en) clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_idx(input logic [3:0] v);
      {a, b, c, d} = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges (called at posedge+1)
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_comb_sweep();
      logic [15:0] exp_tab;
      exp_tab = 16'b1010_0001_1010_1101;
      for (int i = 0; i < 16; i++) begin
         set_idx(4'(i));
         #5;
         vectors++;
         if (F !== exp_tab[i]) begin
            errs++;
            $display("FAIL sweep idx=%0d: F=%b expected %b", i, F, exp_tab[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_idx(4'b0000);
      clk_en = 1'b1;
      tick();
      vectors++;
      if ({F_q, F_chg, ones_cnt} !== 10'd0) begin
         errs++;
         $display("FAIL reset_state: F_q=%b F_chg=%b cnt=%0d expected 0/0/0", F_q, F_chg, ones_cnt);
      end
      rst_n = 1'b1;
      tick(); tick(); tick();
      vectors++;
      if (F_q !== 1'b1 || ones_cnt !== 8'd3) begin
         errs++;
         $display("FAIL run3: F_q=%b cnt=%0d expected 1/3", F_q, ones_cnt);
      end
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (F_q !== 1'b0 || F_chg !== 1'b0 || ones_cnt !== 8'd0 || F !== 1'b1) begin
         errs++;
         $display("FAIL async_reset: F_q=%b F_chg=%b cnt=%0d F=%b expected 0/0/0/1",
                  F_q, F_chg, ones_cnt, F);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_registered();
      do_reset();
      set_idx(4'b0001);
      tick();
      vectors++;
      if (F_q !== 1'b0 || F_chg !== 1'b0) begin
         errs++;
         $display("FAIL reg_idx1: F_q=%b F_chg=%b expected 0/0", F_q, F_chg);
      end
      set_idx(4'b0000);
      tick();
      vectors++;
      if (F_q !== 1'b1 || F_chg !== 1'b1) begin
         errs++;
         $display("FAIL reg_idx0: F_q=%b F_chg=%b expected 1/1", F_q, F_chg);
      end
      tick();
      vectors++;
      if (F_q !== 1'b1 || F_chg !== 1'b0) begin
         errs++;
         $display("FAIL reg_hold: F_q=%b F_chg=%b expected 1/0", F_q, F_chg);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      set_idx(4'b1111);
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 100 || i == 254 || i == 255 || i == 300) begin
            vectors++;
            if (ones_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
               errs++;
               $display("FAIL saturation cycle=%0d: cnt=%0d expected %0d",
                        i, ones_cnt, (i > 255) ? 255 : i);
            end
         end
      end
   endtask

   task automatic test_mixed();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_idx((i % 2 == 0) ? 4'b0100 : 4'b0111);
         tick();
         vectors++;
         if (F_q !== logic'(i % 2) || F_chg !== logic'(i != 0)) begin
            errs++;
            $display("FAIL mixed cycle=%0d: F_q=%b F_chg=%b expected %0d/%0d",
                     i, F_q, F_chg, i % 2, (i != 0));
         end
      end
      vectors++;
      if (ones_cnt !== 8'd5) begin
         errs++;
         $display("FAIL mixed_cnt: cnt=%0d expected 5", ones_cnt);
      end
   endtask

`ifdef CIRCUIT_PROG_TT_EN
   task automatic test_prog_tt();
      do_reset();
      tt_wdata = 16'h0001;
      tt_we    = 1'b1;
      tick();
      tt_we    = 1'b0;
      set_idx(4'b0000);
      #1;
      vectors++;
      if (F !== 1'b1) begin
         errs++;
         $display("FAIL prog_idx0: F=%b expected 1", F);
      end
      set_idx(4'b0101);
      #1;
      vectors++;
      if (F !== 1'b0) begin
         errs++;
         $display("FAIL prog_idx5: F=%b expected 0", F);
      end
      do_reset();
      #1;
      vectors++;
      if (F !== 1'b1) begin
         errs++;
         $display("FAIL prog_after_reset: F=%b expected 1", F);
      end
      tick();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      set_idx(4'b0000);
`ifdef CIRCUIT_PROG_TT_EN
      tt_we    = 1'b0;
      tt_wdata = 16'h0000;
`endif
      test_comb_sweep();
      test_reset();
      test_registered();
      test_saturation();
      test_mixed();
`ifdef CIRCUIT_PROG_TT_EN
      test_prog_tt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
